// File: rtl/cg_iteration_sequencer.sv
// Phase controller for one conjugate-gradient solve: sequences the mXv, vXv and
// update units, copies r into rKold_prev, counts iterations and watches for stuck phases.
module cg_iteration_sequencer #(
   parameter int no_of_units   = 8,
   parameter int memory_height = 1000,
   parameter int address_width = 11,
   parameter int iter_width    = 16,
   parameter int timeout_width = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     go,
   input  logic [31:0]              total,
   input  logic [iter_width-1:0]    max_iterations,
   input  logic                     mxv_done,
   input  logic                     vxv_done,
   input  logic                     update_done,
   input  logic                     converged,
   output logic                     reset_mXv1,
   output logic                     reset_vXv1,
   output logic                     vxv_select,
   output logic                     update_start,
   output logic                     update_select,
   output logic [address_width-1:0] memoryR_read_address,
   output logic [address_width-1:0] rkold_write_address,
   output logic                     memoryRprev_we,
   output logic [iter_width-1:0]    iteration_count,
   output logic                     busy,
   output logic                     finish_all,
   output logic                     converged_flag,
   output logic                     timeout_error
);

   typedef enum logic [3:0] {
      S_IDLE, S_MXV, S_VXV_PAP, S_COPY_R, S_UPD_XR,
      S_VXV_RR, S_CHECK, S_UPD_P, S_DONE, S_ERROR
   } state_t;

   // Expiry is flagged one count early so ERROR is entered as the counter reaches all-ones.
   localparam logic [timeout_width-1:0] WD_LAST = {{(timeout_width-1){1'b1}}, 1'b0};

   state_t                   state_r, next_s;
   logic [timeout_width-1:0] wd_r, wd_n;
   logic [address_width-1:0] words_r, words_n, copy_cnt_r, cnt_n, cnt_inc_s;
   logic [address_width-1:0] rd_n, wa_n;
   logic [iter_width-1:0]    iter_n;
   logic [32:0]              words_full_s;
   logic mxv_ok_s, vxv_ok_s, upd_ok_s, first_s, expire_s, last_iter_s;
   logic start_s, in_copy_s, wait_s, iter_inc_s;
   logic mxv_n, vxv_n, vsel_n, ustart_n, usel_n, we_n, busy_n, fin_n, conv_n, terr_n;

   // A done only counts after the first cycle of the phase that waits on it.
   assign first_s     = (wd_r == {timeout_width{1'b0}});
   assign expire_s    = (wd_r == WD_LAST);
   assign mxv_ok_s    = mxv_done && !first_s;
   assign vxv_ok_s    = vxv_done && !first_s;
   assign upd_ok_s    = update_done && !first_s;
   assign last_iter_s = (({1'b0, iteration_count} + {{iter_width{1'b0}}, 1'b1}) == {1'b0, max_iterations});

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= S_IDLE;
      else        state_r <= next_s;
   end

   // Next-state decode.
   always_comb begin
      next_s = state_r;
      case (state_r)
         S_IDLE:    if (go) next_s = ((total == 32'd0) || (max_iterations == {iter_width{1'b0}})) ? S_DONE : S_MXV;
                    else next_s = S_IDLE;
         S_MXV:     if (mxv_ok_s) next_s = S_VXV_PAP;
                    else if (expire_s) next_s = S_ERROR;
                    else next_s = S_MXV;
         S_VXV_PAP: if (vxv_ok_s) next_s = S_COPY_R;
                    else if (expire_s) next_s = S_ERROR;
                    else next_s = S_VXV_PAP;
         S_COPY_R:  if (copy_cnt_r == words_r) next_s = S_UPD_XR;
                    else next_s = S_COPY_R;
         S_UPD_XR:  if (upd_ok_s) next_s = S_VXV_RR;
                    else if (expire_s) next_s = S_ERROR;
                    else next_s = S_UPD_XR;
         S_VXV_RR:  if (vxv_ok_s) next_s = S_CHECK;
                    else if (expire_s) next_s = S_ERROR;
                    else next_s = S_VXV_RR;
         S_CHECK:   if (converged || last_iter_s) next_s = S_DONE;
                    else next_s = S_UPD_P;
         S_UPD_P:   if (upd_ok_s) next_s = S_MXV;
                    else if (expire_s) next_s = S_ERROR;
                    else next_s = S_UPD_P;
         S_DONE:    next_s = S_IDLE;
         S_ERROR:   next_s = S_IDLE;
         default:   next_s = S_IDLE;
      endcase
   end

   // Output and counter decode, computed from the state being entered so registers track it.
   always_comb begin
      start_s   = (state_r == S_IDLE) && go;
      in_copy_s = (state_r == S_COPY_R) && (next_s == S_COPY_R);
      cnt_inc_s = copy_cnt_r + address_width'(1);
      wait_s    = (state_r == S_MXV) || (state_r == S_VXV_PAP) || (state_r == S_VXV_RR) ||
                  (state_r == S_UPD_XR) || (state_r == S_UPD_P);
      if (wait_s && (next_s == state_r)) wd_n = wd_r + timeout_width'(1);
      else wd_n = {timeout_width{1'b0}};

      words_full_s = ({1'b0, total} + 33'(no_of_units - 1)) / 33'(no_of_units);
      if (!start_s) words_n = words_r;
      else if (words_full_s > 33'(memory_height)) words_n = address_width'(memory_height);
      else words_n = words_full_s[address_width-1:0];

      // Read runs one word ahead of the write; it parks on the last word during the drain cycle.
      cnt_n = in_copy_s ? cnt_inc_s : {address_width{1'b0}};
      if (in_copy_s && (cnt_inc_s < words_r)) rd_n = cnt_inc_s;
      else if (in_copy_s) rd_n = memoryR_read_address;
      else rd_n = {address_width{1'b0}};
      we_n = in_copy_s;
      wa_n = in_copy_s ? memoryR_read_address : {address_width{1'b0}};

      iter_inc_s = ((state_r == S_CHECK) && !converged && last_iter_s) ||
                   ((state_r == S_UPD_P) && upd_ok_s);
      if (start_s) iter_n = {iter_width{1'b0}};
      else if (iter_inc_s && (iteration_count != {iter_width{1'b1}})) iter_n = iteration_count + iter_width'(1);
      else iter_n = iteration_count;

      if (start_s) conv_n = 1'b0;
      else if ((state_r == S_CHECK) && converged) conv_n = 1'b1;
      else conv_n = converged_flag;
      if (start_s) terr_n = 1'b0;
      else if (next_s == S_ERROR) terr_n = 1'b1;
      else terr_n = timeout_error;

      mxv_n    = (next_s != S_MXV);
      vxv_n    = !((next_s == S_VXV_PAP) || (next_s == S_VXV_RR));
      vsel_n   = (next_s == S_VXV_RR);
      usel_n   = (next_s == S_UPD_P);
      ustart_n = ((next_s == S_UPD_XR) || (next_s == S_UPD_P)) && (next_s != state_r);
      busy_n   = (next_s != S_IDLE);
      fin_n    = (next_s == S_DONE);
   end

   // Registered outputs and counters; reset aborts a solve immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_r                 <= {timeout_width{1'b0}};
         words_r              <= {address_width{1'b0}};
         copy_cnt_r           <= {address_width{1'b0}};
         reset_mXv1           <= 1'b1;
         reset_vXv1           <= 1'b1;
         vxv_select           <= 1'b0;
         update_start         <= 1'b0;
         update_select        <= 1'b0;
         memoryR_read_address <= {address_width{1'b0}};
         rkold_write_address  <= {address_width{1'b0}};
         memoryRprev_we       <= 1'b0;
         iteration_count      <= {iter_width{1'b0}};
         busy                 <= 1'b0;
         finish_all           <= 1'b0;
         converged_flag       <= 1'b0;
         timeout_error        <= 1'b0;
      end else begin
         wd_r                 <= wd_n;
         words_r              <= words_n;
         copy_cnt_r           <= cnt_n;
         reset_mXv1           <= mxv_n;
         reset_vXv1           <= vxv_n;
         vxv_select           <= vsel_n;
         update_start         <= ustart_n;
         update_select        <= usel_n;
         memoryR_read_address <= rd_n;
         rkold_write_address  <= wa_n;
         memoryRprev_we       <= we_n;
         iteration_count      <= iter_n;
         busy                 <= busy_n;
         finish_all           <= fin_n;
         converged_flag       <= conv_n;
         timeout_error        <= terr_n;
      end
   end

endmodule

// File: tb/tb_cg_iteration_sequencer.sv
// Directed bench for cg_iteration_sequencer: a responder plays the phase units, a scoreboard
// holds expected rKold_prev writes and end-of-solve results.
module tb_cg_iteration_sequencer;

   logic        clk, reset, go, converged;
   logic [31:0] total;
   logic [15:0] max_iterations;
   logic        mxv_done, vxv_done, update_done;
   logic        reset_mXv1, reset_vXv1, vxv_select, update_start, update_select;
   logic [10:0] memoryR_read_address, rkold_write_address;
   logic        memoryRprev_we, busy, finish_all, converged_flag, timeout_error;
   logic [15:0] iteration_count;

   int errors = 0;
   int checks = 0;
   int wr_q[$];
   logic [16:0] fin_q[$];
   int mxv_entries, mxv_len, vxv_low, upd_pulses, fin_cnt;
   bit mxv_stuck = 1'b0;
   bit block_vxv = 1'b0;
   logic [10:0] prev_rd;
   logic prev_mxv_idle;

   cg_iteration_sequencer #(.timeout_width(4)) dut (
      .clk(clk), .reset(reset), .go(go), .total(total), .max_iterations(max_iterations),
      .mxv_done(mxv_done), .vxv_done(vxv_done), .update_done(update_done), .converged(converged),
      .reset_mXv1(reset_mXv1), .reset_vXv1(reset_vXv1), .vxv_select(vxv_select),
      .update_start(update_start), .update_select(update_select),
      .memoryR_read_address(memoryR_read_address), .rkold_write_address(rkold_write_address),
      .memoryRprev_we(memoryRprev_we), .iteration_count(iteration_count), .busy(busy),
      .finish_all(finish_all), .converged_flag(converged_flag), .timeout_error(timeout_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Responder: each unit raises its done in the fourth cycle of its phase.
   initial begin
      int ph, cnt, nph;
      ph = 0; cnt = 0;
      mxv_done = 1'b0; vxv_done = 1'b0; update_done = 1'b0;
      forever begin
         @(negedge clk);
         if (update_start) begin ph = 4; cnt = 0; end
         else if (!reset_mXv1) begin
            if (ph != 1) begin ph = 1; cnt = 0; end else cnt++;
         end else if (!reset_vXv1) begin
            nph = vxv_select ? 3 : 2;
            if (ph != nph) begin ph = nph; cnt = 0; end else cnt++;
         end else if (ph == 4 && busy) cnt++;
         else begin ph = 0; cnt = 0; end
         mxv_done    = mxv_stuck || (ph == 1 && cnt == 3);
         vxv_done    = !block_vxv && (ph == 2 || ph == 3) && cnt == 3;
         update_done = (ph == 4 && cnt == 3);
      end
   end

   // Monitor: scoreboard pops plus phase statistics.
   initial begin
      int exp_wa;
      logic [16:0] exp_fin;
      prev_rd = 11'd0; prev_mxv_idle = 1'b1;
      forever begin
         @(negedge clk);
         if (memoryRprev_we) begin
            if (wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
               exp_wa = wr_q.pop_front();
               check("rkold_addr", 32'(rkold_write_address), 32'(exp_wa));
               check("wr_follows_rd", 32'(rkold_write_address), 32'(prev_rd));
            end
         end
         if (finish_all) begin
            fin_cnt++;
            if (fin_q.size() == 0) check("fin_unexpected", 32'd1, 32'd0);
            else begin
               exp_fin = fin_q.pop_front();
               check("fin_conv_iter", 32'({converged_flag, iteration_count}), 32'(exp_fin));
            end
         end
         if (!reset_mXv1) mxv_len++;
         if (!reset_mXv1 && prev_mxv_idle) mxv_entries++;
         if (!reset_vXv1) vxv_low++;
         if (update_start) upd_pulses++;
         prev_rd = memoryR_read_address;
         prev_mxv_idle = reset_mXv1;
      end
   end

   task automatic clear_stats();
      mxv_entries = 0; mxv_len = 0; vxv_low = 0; upd_pulses = 0;
   endtask

   task automatic run_solve(input int t, input int mi, input logic cv, input int passes,
                            input int words, input int fin_iter, input logic fin_conv,
                            input bit go_again);
      for (int p = 0; p < passes; p++)
         for (int w = 0; w < words; w++) wr_q.push_back(w);
      fin_q.push_back({fin_conv, 16'(fin_iter)});
      clear_stats();
      total = 32'(t); max_iterations = 16'(mi); converged = cv;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      if (go_again) begin
         go = 1'b1;
         @(negedge clk);
         go = 1'b0;
         check("go_ignored_mxv", 32'(reset_mXv1), 32'd0);
      end
      for (int i = 0; i < 3000 && busy; i++) @(negedge clk);
      check("solve_ends", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      reset = 1'b0; go = 1'b0; converged = 1'b0; total = 32'd0; max_iterations = 16'd0;
      fin_cnt = 0;
      clear_stats();
      repeat (3) @(negedge clk);
      check("rst_mxv", 32'(reset_mXv1), 32'd1);
      check("rst_vxv", 32'(reset_vXv1), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_we", 32'(memoryRprev_we), 32'd0);
      check("rst_misc", 32'({finish_all, converged_flag, timeout_error, update_start, iteration_count}), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // Single iteration, converges at first CHECK: two words copied.
      run_solve(16, 5, 1'b1, 1, 2, 0, 1'b1, 1'b0);
      check("t1_mxv_entries", 32'(mxv_entries), 32'd1);
      check("t1_upd_pulses", 32'(upd_pulses), 32'd1);
      check("t1_wr_drained", 32'(wr_q.size()), 32'd0);
      check("t1_fin_drained", 32'(fin_q.size()), 32'd0);

      // Iteration limit: three full passes.
      run_solve(9, 3, 1'b0, 3, 2, 3, 1'b0, 1'b0);
      check("t2_mxv_entries", 32'(mxv_entries), 32'd3);
      check("t2_upd_pulses", 32'(upd_pulses), 32'd5);
      check("t2_wr_drained", 32'(wr_q.size()), 32'd0);
      check("t2_fin_drained", 32'(fin_q.size()), 32'd0);

      // Stale done: mxv_done stuck high everywhere.
      mxv_stuck = 1'b1;
      repeat (3) @(negedge clk);
      check("stale_idle_busy", 32'(busy), 32'd0);
      run_solve(8, 1, 1'b1, 1, 1, 0, 1'b1, 1'b0);
      check("stale_mxv_len", 32'(mxv_len >= 2), 32'd1);
      check("stale_mxv_entries", 32'(mxv_entries), 32'd1);
      mxv_stuck = 1'b0;

      // Watchdog: vxv_done withheld.
      block_vxv = 1'b1;
      clear_stats();
      total = 32'd8; max_iterations = 16'd2; converged = 1'b0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 200 && !timeout_error; i++) @(negedge clk);
      check("to_seen", 32'(timeout_error), 32'd1);
      check("to_vxv_cycles", 32'(vxv_low), 32'd15);
      check("to_vxv_released", 32'(reset_vXv1), 32'd1);
      check("to_error_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("to_back_idle", 32'(busy), 32'd0);
      repeat (5) @(negedge clk);
      check("to_sticky", 32'(timeout_error), 32'd1);
      check("to_no_finish", 32'(fin_q.size() + wr_q.size()), 32'd0);
      block_vxv = 1'b0;

      // total == 0: straight to DONE, and go clears the timeout flag.
      fin_q.push_back({1'b0, 16'd0});
      total = 32'd0; max_iterations = 16'd5;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("t0_finish", 32'(finish_all), 32'd1);
      check("t0_busy", 32'(busy), 32'd1);
      check("t0_to_cleared", 32'(timeout_error), 32'd0);
      @(negedge clk);
      check("t0_finish_pulse", 32'({finish_all, busy}), 32'd0);

      // max_iterations == 0.
      fin_q.push_back({1'b0, 16'd0});
      total = 32'd8; max_iterations = 16'd0;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      check("m0_finish", 32'(finish_all), 32'd1);
      check("m0_iter", 32'(iteration_count), 32'd0);
      @(negedge clk);
      check("m0_finish_pulse", 32'({finish_all, busy}), 32'd0);

      // go during MXV is ignored.
      run_solve(8, 1, 1'b1, 1, 1, 0, 1'b1, 1'b1);
      check("gomxv_entries", 32'(mxv_entries), 32'd1);

      // Async reset in the middle of COPY_R.
      for (int w = 0; w < 8; w++) wr_q.push_back(w);
      total = 32'd64; max_iterations = 16'd1; converged = 1'b1;
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      for (int i = 0; i < 200 && !memoryRprev_we; i++) @(negedge clk);
      check("ar_in_copy", 32'(memoryRprev_we), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("ar_we", 32'(memoryRprev_we), 32'd0);
      check("ar_busy", 32'(busy), 32'd0);
      check("ar_idle_ctl", 32'({reset_mXv1, reset_vXv1}), 32'd3);
      wr_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_solve(16, 1, 1'b1, 1, 2, 0, 1'b1, 1'b0);
      check("ar_rerun_entries", 32'(mxv_entries), 32'd1);
      check("ar_rerun_drained", 32'(wr_q.size() + fin_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
